cla_seq_multiplier_8bit: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier. It sits directly downstream of the 8-bit carry-look-ahead adder. It instantiates one Carry_Look_Ahead_Adder_8bit and reuses it every cycle for partial-product accumulation, taking the adder's s and c8 each iteration. It exposes a valid/ready handshake on both input and output so it can feed datapath stages in later labs.

---
 rtl/cla_seq_multiplier_8bit.sv | 110 +++++++++++
 tb/tb_cla_seq_multiplier_8bit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cla_seq_multiplier_8bit.sv
// cla_seq_multiplier_8bit: 8x8 unsigned shift-and-add multiplier reusing one 8-bit CLA per iteration
module Carry_Look_Ahead_Adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c0,
    output logic [7:0] s,
    output logic       c8
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       prop;
    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;
        prop = 1'b0;
        c[0] = c0;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = c[i+1] | (prop & c0);
        end
        s = p ^ c[7:0];
        c8 = c[8];
    end
endmodule

module cla_seq_multiplier_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        ready,
    output logic        valid,
    input  logic        out_ready,
    output logic [15:0] p
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  mq_q, mq_d;
    logic [7:0]  acc_hi_q, acc_hi_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] p_q, p_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [7:0]  sum;
    logic        c8;
    Carry_Look_Ahead_Adder_8bit u_cla (
        .a  (acc_hi_q),
        .b  (mq_q[0] ? mcand_q : 8'h00),
        .c0 (1'b0),
        .s  (sum),
        .c8 (c8)
    );
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mq_d = mq_q;
        acc_hi_d = acc_hi_q;
        cnt_d = cnt_q;
        p_d = p_q;
        if (state_q == IDLE && start) begin
            mcand_d = a;
            mq_d = b;
            acc_hi_d = '0;
            cnt_d = '0;
            state_d = CALC;
        end else if (state_q == CALC) begin
            {acc_hi_d, mq_d} = {c8, sum, mq_q[7:1]};
            cnt_d = cnt_q + 3'd1;
            p_d = (cnt_q == 3'd7) ? {c8, sum, mq_q[7:1]} : p_q;
            state_d = (cnt_q == 3'd7) ? DONE : CALC;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mq_q <= '0;
            acc_hi_q <= '0;
            cnt_q <= '0;
            p_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mq_q <= mq_d;
            acc_hi_q <= acc_hi_d;
            cnt_q <= cnt_d;
            p_q <= p_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end
    assign ready = ready_q;
    assign valid = valid_q;
    assign p = p_q;
endmodule

// File: tb/tb_cla_seq_multiplier_8bit.sv
// tb_cla_seq_multiplier_8bit: directed and random checks of the sequential multiplier against plain a*b
module tb_cla_seq_multiplier_8bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        out_ready = 1'b1;
    logic        ready;
    logic        valid;
    logic [15:0] p;
    int checks = 0;
    int errors = 0;

    cla_seq_multiplier_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .valid     (valid),
        .out_ready (out_ready),
        .p         (p)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb);
        logic [15:0] exp;
        int n;
        exp = 16'(ta) * 16'(tb);
        chk("ready_before_start", 16'(ready), 16'd1);
        start = 1'b1;
        a = ta;
        b = tb;
        step();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        chk("ready_after_accept", 16'(ready), 16'd0);
        n = 0;
        while (!valid && n < 20) begin
            step();
            n++;
        end
        chk("latency", 16'(n), 16'd8);
        chk("product", p, exp);
        step();
        chk("idle_after_done", 16'(ready), 16'd1);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("reset_ready", 16'(ready), 16'd1);
        chk("reset_valid", 16'(valid), 16'd0);
        chk("reset_p", p, 16'h0000);

        run_op(8'd13, 8'd11);
        run_op(8'hFF, 8'hFF);
        run_op(8'h80, 8'h02);
        run_op(8'h00, 8'hFF);
        run_op(8'h01, 8'hA5);
        run_op(8'hA5, 8'h01);

        out_ready = 1'b0;
        start = 1'b1;
        a = 8'd200;
        b = 8'd3;
        step();
        chk("bp_ready_after_accept", 16'(ready), 16'd0);
        for (int i = 0; i < 8; i++) begin
            start = 1'b1;
            a = 8'd1;
            b = 8'd1;
            step();
            start = 1'b0;
        end
        chk("bp_valid", 16'(valid), 16'd1);
        chk("bp_product", p, 16'd600);
        for (int i = 0; i < 20; i++) begin
            start = (i % 2 == 0);
            step();
            chk("bp_hold_valid", 16'(valid), 16'd1);
            chk("bp_hold_p", p, 16'd600);
        end
        start = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_ready", 16'(ready), 16'd1);
        chk("bp_release_valid", 16'(valid), 16'd0);
        chk("bp_release_p", p, 16'd600);

        start = 1'b1;
        a = 8'd9;
        b = 8'd9;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midreset_ready", 16'(ready), 16'd1);
        chk("midreset_valid", 16'(valid), 16'd0);
        chk("midreset_p", p, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("midreset_no_valid", 16'(valid), 16'd0);
        end
        run_op(8'd7, 8'd6);

        for (int i = 0; i < 30; i++) run_op(8'(i * 5), 8'(i * 7));
        for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
